// File: rtl/gf180_ram_bank_as2650_pkg.sv
// Shared constants, state type and sizing helper
// for the AS2650 on-die SRAM bank.
package gf180_ram_pkg_as2650;

    localparam int MACRO_DEPTH = 512;
    localparam int MACRO_AW    = 9;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    function automatic int banks(input int words);
        return words / MACRO_DEPTH;
    endfunction

endpackage

// File: rtl/gf180_ram_bank_as2650_if.sv
// Request/response port of the SRAM bank.
// master = bus side, slave = RAM side.
interface gf180_ram_bank_as2650_if #(
    parameter int AW    = 10,
    parameter int BYTES = 2
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [BYTES-1:0]   req_be;
    logic [AW-1:0]      req_addr;
    logic [8*BYTES-1:0] req_wdata;
    logic               rsp_valid;
    logic [8*BYTES-1:0] rsp_rdata;
    logic               init_done;

    modport master (
        output req_valid, req_we, req_be,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid,
        input  rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_we, req_be,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid,
        output rsp_rdata, init_done
    );
endinterface

// File: rtl/gf180_ram_512x8_wrapper_as2650.sv
// Single 512x8 macro wrapper; active-low controls,
// 1-cycle synchronous read, bit-masked write.
module gf180_ram_512x8_wrapper_as2650
    import gf180_ram_pkg_as2650::*;
(
`ifdef USE_POWER_PINS
    inout  wire                VDD,
    inout  wire                VSS,
`endif
    input  logic                clk,
    input  logic                cen,
    input  logic                gwen,
    input  logic [7:0]          wen,
    input  logic [MACRO_AW-1:0] a,
    input  logic [7:0]          d,
    output logic [7:0]          q
);
    logic [7:0] mem [MACRO_DEPTH];

    // Q holds its last value on writes and idle cycles
    always_ff @(posedge clk) begin
        if (!cen && !gwen)
            mem[a] <= (mem[a] & wen) | (d & ~wen);
        if (!cen && gwen)
            q <= mem[a];
    end
endmodule

// File: rtl/gf180_ram_bank_as2650.sv
// Tiled SRAM bank: valid/ready port, byte enables,
// bank decode and optional post-reset clear sweep.
module gf180_ram_bank_as2650
    import gf180_ram_pkg_as2650::*;
#(
    parameter int WORDS    = 1024,
    parameter int BYTES    = 2,
    parameter int CLEAR_EN = 1
) (
`ifdef USE_POWER_PINS
    inout  wire VDD,
    inout  wire VSS,
`endif
    input  logic clk,
    input  logic rst,
    gf180_ram_bank_as2650_if.slave bus
);
    localparam int BANKS = banks(WORDS);
    localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;

    if ((WORDS % MACRO_DEPTH) != 0 || WORDS < MACRO_DEPTH ||
        WORDS > 4096 || BYTES < 1 || BYTES > 4) begin : g_bad
        $error("gf180_ram_bank_as2650: bad WORDS/BYTES");
    end

    state_t state, nxt;
    logic [MACRO_AW-1:0]         cnt;
    logic                        rdy_q;
    logic                        rv_q;
    logic [BW-1:0]               rbank_q;
    logic [BW-1:0]               bank;
    logic                        fire;
    logic                        rd_fire;

    logic [BANKS-1:0]            cen;
    logic                        gwen;
    logic [BYTES-1:0][7:0]       wen;
    logic [MACRO_AW-1:0]         addr;
    logic [BYTES-1:0][7:0]       din;
    logic [BANKS-1:0][BYTES-1:0][7:0] q;

    assign bank    = BW'(bus.req_addr >> MACRO_AW);
    assign fire    = bus.req_valid && rdy_q;
    assign rd_fire = fire && !bus.req_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
            cnt     <= '0;
            rdy_q   <= 1'b0;
            rv_q    <= 1'b0;
            rbank_q <= '0;
        end else begin
            state <= nxt;
            cnt   <= (state == ST_CLEAR) ? cnt + 9'd1 : '0;
            rdy_q <= (nxt == ST_IDLE);
            rv_q  <= rd_fire;
            if (rd_fire)
                rbank_q <= bank;
        end
    end

    // Macros stay idle whenever rst is high, even though state is CLEAR
    always_comb begin
        nxt  = state;
        cen  = '1;
        gwen = 1'b1;
        wen  = '1;
        addr = bus.req_addr[MACRO_AW-1:0];
        din  = bus.req_wdata;
        unique case (1'b1)
            state == ST_CLEAR: begin
                if (cnt == 9'd511)
                    nxt = ST_IDLE;
                addr = cnt;
                din  = '0;
                if (!rst) begin
                    cen  = '0;
                    gwen = 1'b0;
                    wen  = '0;
                end
            end
            state == ST_IDLE: begin
                if (fire) begin
                    cen[bank] = 1'b0;
                    gwen      = !bus.req_we;
                    for (int i = 0; i < BYTES; i++)
                        wen[i] = bus.req_be[i] ? 8'h00 : 8'hFF;
                end
            end
            default: ;
        endcase
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar y = 0; y < BYTES; y++) begin : g_byte
            gf180_ram_512x8_wrapper_as2650 u_ram (
`ifdef USE_POWER_PINS
                .VDD  (VDD),
                .VSS  (VSS),
`endif
                .clk  (clk),
                .cen  (cen[b]),
                .gwen (gwen),
                .wen  (wen[y]),
                .a    (addr),
                .d    (din[y]),
                .q    (q[b][y])
            );
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.init_done = rdy_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_rdata = q[rbank_q];
endmodule

// File: tb/tb_gf180_ram_bank_as2650.sv
// Directed bench for gf180_ram_bank_as2650 (clear sweep,
// byte enables, bank decode, hazards, reset).
module tb_gf180_ram_bank_as2650;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_eval = 0;
    int   n_fail = 0;
    int   n;

    always #5 clk = ~clk;

    gf180_ram_bank_as2650_if #(.AW(10), .BYTES(2)) bus ();
    gf180_ram_bank_as2650_if #(.AW(10), .BYTES(2)) bus2 ();

    gf180_ram_bank_as2650 #(
        .WORDS(1024), .BYTES(2), .CLEAR_EN(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    gf180_ram_bank_as2650 #(
        .WORDS(1024), .BYTES(2), .CLEAR_EN(0)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 2'b00;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d,
                      input logic [1:0] be);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = be;
        bus.req_addr  = a;
        bus.req_wdata = d;
        cyc();
        idle();
    endtask

    task automatic rd(input string tag, input logic [9:0] a,
                      input logic [15:0] exp);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        cyc();
        idle();
        chk({tag, "_vld"}, bus.rsp_valid, 1);
        chk({tag, "_dat"}, bus.rsp_rdata, exp);
    endtask

    task automatic wait_clear(input string tag);
        n = 0;
        while (!bus.req_ready && n < 600) begin
            cyc();
            n++;
        end
        chk({tag, "_len"}, n, 512);
        chk({tag, "_done"}, bus.init_done, 1);
    endtask

    initial begin
        idle();
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus2.req_valid = 1'b0;
        bus2.req_we    = 1'b0;
        bus2.req_be    = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;

        // 1: reset values, sweep length, CLEAR_EN=0 readiness
        cyc();
        cyc();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp", bus.rsp_valid, 0);
        chk("rst_done", bus.init_done, 0);
        chk("rst_cen", dut.cen, 2'b11);
        rst = 1'b0;
        #1;
        chk("noclr_rdy0", bus2.req_ready, 0);
        chk("clr_cen", dut.cen, 2'b00);
        cyc();
        chk("noclr_rdy1", bus2.req_ready, 1);
        chk("clr_rdy1", bus.req_ready, 0);
        n = 1;
        while (!bus.req_ready && n < 600) begin
            cyc();
            n++;
        end
        chk("clr1_len", n, 512);
        chk("clr1_done", bus.init_done, 1);
        rd("rd3ff", 10'h3FF, 16'h0000);
        cyc();
        chk("pulse", bus.rsp_valid, 0);

        // 2: full write then read, 1-cycle latency
        wr(10'h005, 16'hBEEF, 2'b11);
        chk("wr_norsp", bus.rsp_valid, 0);
        rd("beef", 10'h005, 16'hBEEF);

        // 3: byte enables
        wr(10'h005, 16'h1234, 2'b01);
        rd("be01", 10'h005, 16'hBE34);
        wr(10'h005, 16'hFFFF, 2'b00);
        chk("be00_norsp", bus.rsp_valid, 0);
        rd("be00", 10'h005, 16'hBE34);

        // 4: back-to-back reads across banks
        wr(10'h001, 16'hAAAA, 2'b11);
        wr(10'h201, 16'h5555, 2'b11);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h001;
        cyc();
        bus.req_addr  = 10'h201;
        #1;
        chk("b2b_cen", dut.cen, 2'b01);
        chk("b2b0_vld", bus.rsp_valid, 1);
        chk("b2b0_dat", bus.rsp_rdata, 16'hAAAA);
        cyc();
        idle();
        chk("b2b1_vld", bus.rsp_valid, 1);
        chk("b2b1_dat", bus.rsp_rdata, 16'h5555);
        cyc();
        chk("b2b_end", bus.rsp_valid, 0);

        // 5: write-after-read returns old, then new
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h010;
        cyc();
        bus.req_we    = 1'b1;
        bus.req_be    = 2'b11;
        bus.req_wdata = 16'hCAFE;
        #1;
        chk("war_vld", bus.rsp_valid, 1);
        chk("war_old", bus.rsp_rdata, 16'h0000);
        cyc();
        idle();
        rd("war_new", 10'h010, 16'hCAFE);

        // 6: reset at clear count 300 and mid-read
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 300; i++)
            cyc();
        chk("cnt300", dut.cnt, 300);
        rst = 1'b1;
        #1;
        chk("rst300_rdy", bus.req_ready, 0);
        chk("rst300_cen", dut.cen, 2'b11);
        cyc();
        rst = 1'b0;
        wait_clear("clr2");
        rd("clr2_rd", 10'h005, 16'h0000);

        wr(10'h205, 16'h7788, 2'b11);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h205;
        cyc();
        idle();
        chk("mid_vld", bus.rsp_valid, 1);
        chk("mid_dat", bus.rsp_rdata, 16'h7788);
        rst = 1'b1;
        #1;
        chk("mid_drop", bus.rsp_valid, 0);
        chk("mid_done", bus.init_done, 0);
        cyc();
        rst = 1'b0;
        wait_clear("clr3");
        rd("clr3_rd", 10'h205, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_eval, n_fail);
        $finish;
    end
endmodule
